people_counter: RTL and testbench

PEOPLE_COUNTER -- requirements
Module: people_counter

---
 rtl/sbqm_pkg.sv | 17 +
 rtl/sensor_conditioner.sv | 73 +++++++
 rtl/people_counter.sv | 100 ++++++++++
 tb/tb_people_counter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sbqm_pkg.sv
// Shared constants and types for the queue-management blocks (people counter, queue status).
package sbqm_pkg;

    localparam int unsigned PCOUNT_W      = 3;
    localparam int unsigned DB_CYCLES_DEF = 4;

    // One-cycle event pulses produced by the counter stage.
    typedef struct packed {
        logic entry;
        logic leave;
        logic rej_full;
        logic rej_empty;
    } pc_evt_t;

    localparam pc_evt_t PC_EVT_NONE = '{entry: 1'b0, leave: 1'b0, rej_full: 1'b0, rej_empty: 1'b0};

endpackage

// File: rtl/sensor_conditioner.sv
// Photocell conditioner: two-flop synchronizer, optional debounce (DEBOUNCE_EN), fall detect.
// fall_o is a single-cycle strobe seen after the conditioned level drops 1->0.
module sensor_conditioner
    import sbqm_pkg::*;
#(
    parameter int unsigned DbCycles = DB_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sensor_i,
    output logic fall_o
);

    logic sync1_q, sync2_q;
    logic prev_q;
    logic level;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= sensor_i;
            sync2_q <= sync1_q;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int unsigned CntW = (DbCycles > 1) ? $clog2(DbCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DbCycles - 1);

    logic            level_q, level_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    // Level follows the synchronized input only after DbCycles consecutive differing samples.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    assign fall_o = prev_q & ~level;

endmodule

// File: rtl/people_counter.sv
// Queue occupancy counter fed by entry/exit photocells, saturating at 0 and 2^N-1.
// Optional sensor debounce is enabled with the DEBOUNCE_EN macro.
module people_counter
    import sbqm_pkg::*;
#(
    parameter int unsigned N         = PCOUNT_W,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         front_sensor,
    input  logic         back_sensor,
    output logic [N-1:0] Pcount,
    output logic         entry_evt,
    output logic         exit_evt,
    output logic         reject_full,
    output logic         reject_empty
);

    localparam logic [N-1:0] MaxCount = '1;

    logic up, dn;

    sensor_conditioner #(
        .DbCycles (DB_CYCLES)
    ) u_front (
        .clk_i    (clk),
        .rst_i    (rst),
        .sensor_i (front_sensor),
        .fall_o   (up)
    );

    sensor_conditioner #(
        .DbCycles (DB_CYCLES)
    ) u_back (
        .clk_i    (clk),
        .rst_i    (rst),
        .sensor_i (back_sensor),
        .fall_o   (dn)
    );

    logic [N-1:0] count_q, count_d;
    pc_evt_t      evt_q, evt_d;

    always_comb begin
        count_d = count_q;
        evt_d   = PC_EVT_NONE;
        case ({up, dn})
            2'b10: begin
                if (count_q != MaxCount) begin
                    count_d     = count_q + 1'b1;
                    evt_d.entry = 1'b1;
                end else begin
                    evt_d.rej_full = 1'b1;
                end
            end
            2'b01: begin
                if (count_q != '0) begin
                    count_d     = count_q - 1'b1;
                    evt_d.leave = 1'b1;
                end else begin
                    evt_d.rej_empty = 1'b1;
                end
            end
            2'b11: begin
                // At a bound the side that would overflow is rejected; the other still counts.
                if (count_q == '0) begin
                    count_d         = count_q + 1'b1;
                    evt_d.entry     = 1'b1;
                    evt_d.rej_empty = 1'b1;
                end else if (count_q == MaxCount) begin
                    count_d        = count_q - 1'b1;
                    evt_d.leave    = 1'b1;
                    evt_d.rej_full = 1'b1;
                end else begin
                    evt_d.entry = 1'b1;
                    evt_d.leave = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            evt_q   <= PC_EVT_NONE;
        end else begin
            count_q <= count_d;
            evt_q   <= evt_d;
        end
    end

    assign Pcount       = count_q;
    assign entry_evt    = evt_q.entry;
    assign exit_evt     = evt_q.leave;
    assign reject_full  = evt_q.rej_full;
    assign reject_empty = evt_q.rej_empty;

endmodule

// File: tb/tb_people_counter.sv
// Directed self-checking bench for people_counter (N=3); follows DEBOUNCE_EN when defined.
module tb_people_counter;

`ifdef DEBOUNCE_EN
    localparam int Lat     = 7;
    localparam int HighCyc = 8;
`else
    localparam int Lat     = 3;
    localparam int HighCyc = 5;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       front_sensor;
    logic       back_sensor;
    logic [2:0] Pcount;
    logic       entry_evt, exit_evt, reject_full, reject_empty;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    people_counter #(
        .N         (3),
        .DB_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .front_sensor (front_sensor),
        .back_sensor  (back_sensor),
        .Pcount       (Pcount),
        .entry_evt    (entry_evt),
        .exit_evt     (exit_evt),
        .reject_full  (reject_full),
        .reject_empty (reject_empty)
    );

    // Event vector order: {entry, exit, reject_full, reject_empty}
    function automatic logic [3:0] evts();
        return {entry_evt, exit_evt, reject_full, reject_empty};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One pass: raise selected sensors for `high` cycles, lower them, expect the result at Lat.
    task automatic run_pass(input logic f, input logic b, input int high, input int prev,
                            input int exp_cnt, input logic [3:0] exp_evt, input string tag);
        logic [3:0] acc;
        acc = '0;
        front_sensor = f;
        back_sensor  = b;
        repeat (high) begin
            @(negedge clk);
            acc = acc | evts();
        end
        check({tag, "_hi_evt"}, int'(acc), 0);
        check({tag, "_hi_cnt"}, int'(Pcount), prev);
        front_sensor = 1'b0;
        back_sensor  = 1'b0;
        acc = '0;
        for (int i = 1; i <= Lat + 1; i++) begin
            @(negedge clk);
            if (i < Lat) begin
                acc = acc | evts();
                if (i == Lat - 1) begin
                    check({tag, "_early_evt"}, int'(acc), 0);
                    check({tag, "_early_cnt"}, int'(Pcount), prev);
                end
            end else if (i == Lat) begin
                check({tag, "_evt"}, int'(evts()), int'(exp_evt));
                check({tag, "_cnt"}, int'(Pcount), exp_cnt);
            end else begin
                check({tag, "_post_evt"}, int'(evts()), 0);
                check({tag, "_post_cnt"}, int'(Pcount), exp_cnt);
            end
        end
        repeat (HighCyc) @(negedge clk);
    endtask

    initial begin
        logic [3:0] acc;
        rst          = 1'b1;
        front_sensor = 1'b0;
        back_sensor  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cnt", int'(Pcount), 0);
        check("rst_evt", int'(evts()), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_cnt", int'(Pcount), 0);
        check("post_rst_evt", int'(evts()), 0);

        // Fill to 7 with entries.
        run_pass(1, 0, HighCyc, 0, 1, 4'b1000, "in1");
        run_pass(1, 0, HighCyc, 1, 2, 4'b1000, "in2");
        run_pass(1, 0, HighCyc, 2, 3, 4'b1000, "in3");
        run_pass(1, 0, HighCyc, 3, 4, 4'b1000, "in4");
        run_pass(1, 0, HighCyc, 4, 5, 4'b1000, "in5");
        run_pass(1, 0, HighCyc, 5, 6, 4'b1000, "in6");
        run_pass(1, 0, HighCyc, 6, 7, 4'b1000, "in7");
        run_pass(1, 0, HighCyc, 7, 7, 4'b0010, "full");
        run_pass(0, 1, HighCyc, 7, 6, 4'b0100, "out6");

        // Drain to 0, then underflow and simultaneous-at-zero.
        run_pass(0, 1, HighCyc, 6, 5, 4'b0100, "out5");
        run_pass(0, 1, HighCyc, 5, 4, 4'b0100, "out4");
        run_pass(0, 1, HighCyc, 4, 3, 4'b0100, "out3");
        run_pass(0, 1, HighCyc, 3, 2, 4'b0100, "out2");
        run_pass(0, 1, HighCyc, 2, 1, 4'b0100, "out1");
        run_pass(0, 1, HighCyc, 1, 0, 4'b0100, "out0");
        run_pass(0, 1, HighCyc, 0, 0, 4'b0001, "empty");
        run_pass(1, 1, HighCyc, 0, 1, 4'b1001, "both0");

        // Simultaneous mid-range, then at full.
        run_pass(1, 0, HighCyc, 1, 2, 4'b1000, "up2");
        run_pass(1, 0, HighCyc, 2, 3, 4'b1000, "up3");
        run_pass(1, 0, 30, 3, 4, 4'b1000, "longhold");
        run_pass(1, 1, HighCyc, 4, 4, 4'b1100, "both4");
        run_pass(1, 0, HighCyc, 4, 5, 4'b1000, "up5");
        run_pass(1, 0, HighCyc, 5, 6, 4'b1000, "up6");
        run_pass(1, 0, HighCyc, 6, 7, 4'b1000, "up7");
        run_pass(1, 1, HighCyc, 7, 6, 4'b0110, "both7");
        run_pass(0, 1, HighCyc, 6, 5, 4'b0100, "dn5");

`ifdef DEBOUNCE_EN
        // Short glitch must be filtered out.
        acc = '0;
        front_sensor = 1'b1;
        repeat (2) @(negedge clk);
        front_sensor = 1'b0;
        repeat (15) begin
            @(negedge clk);
            acc = acc | evts();
        end
        check("glitch_evt", int'(acc), 0);
        check("glitch_cnt", int'(Pcount), 5);
`endif

        // Reset in the middle of a pass; sensor still high afterwards.
        acc = '0;
        front_sensor = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_cnt1", int'(Pcount), 0);
        @(negedge clk);
        check("midrst_cnt2", int'(Pcount), 0);
        check("midrst_evt", int'(evts()), 0);
        rst = 1'b0;
        run_pass(1, 0, 10, 0, 1, 4'b1000, "afterrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
